// File: rtl/delay_line_mc.sv
`default_nettype none
// ============================================================================
//  Module      : delay_line_mc
//  Description : Multi-channel circular-buffer delay line; one damped tap per
//                output channel, all channels published together.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_line_mc #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 256,
    parameter int CHANNELS = 2,
    parameter int GAIN_W   = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               sample_en,
    input  logic [DATA_W-1:0]                  signal_in,
    input  logic [CHANNELS*$clog2(DEPTH)-1:0]  delay,
    input  logic [CHANNELS*GAIN_W-1:0]         damp,
    output logic [CHANNELS*DATA_W-1:0]         signal_out,
    output logic                               out_valid,
    output logic                               overrun
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PROD_W = DATA_W + GAIN_W;
    localparam logic [CH_W-1:0]   C_LAST_CH = CH_W'(CHANNELS - 1);
    localparam logic [ADDR_W:0]   C_FULL    = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_MAC   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [DATA_W-1:0]           r_mem [DEPTH];
    logic [DATA_W-1:0]           r_rdata;
    logic [ADDR_W-1:0]           r_wr_ptr;
    logic [ADDR_W:0]             r_fill;
    logic [CH_W-1:0]             r_ch;
    logic [DATA_W-1:0]           r_sample;
    logic [CHANNELS*ADDR_W-1:0]  r_delay;
    logic [CHANNELS*GAIN_W-1:0]  r_damp;
    logic [CHANNELS*DATA_W-1:0]  w_shadow_flat;
    logic [ADDR_W-1:0]           w_delay_ch;
    logic [GAIN_W-1:0]           w_damp_ch;
    logic [ADDR_W-1:0]           w_mem_addr;
    logic                        w_mem_we;
    logic                        w_tap_valid;
    logic signed [PROD_W-1:0]    w_data_ext;
    logic signed [PROD_W-1:0]    w_gain_ext;
    logic signed [PROD_W-1:0]    w_product;
    logic [DATA_W-1:0]           w_result;
    logic [GAIN_W-1:0]           w_frac_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (sample_en) w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_READ;
            S_READ:  w_next_state = S_MAC;
            S_MAC: begin
                if (r_ch == C_LAST_CH) w_next_state = S_DONE;
                else                   w_next_state = S_READ;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_delay_ch = '0;
        w_damp_ch  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_ch == CH_W'(c)) begin
                w_delay_ch = r_delay[c*ADDR_W +: ADDR_W];
                w_damp_ch  = r_damp[c*GAIN_W +: GAIN_W];
            end
        end
    end

    assign w_mem_we    = (r_state == S_WRITE);
    assign w_mem_addr  = w_mem_we ? r_wr_ptr : (r_wr_ptr - w_delay_ch);
    // fill already includes the current sample by the time MAC evaluates it
    assign w_tap_valid = ({1'b0, w_delay_ch} < r_fill);

    // The product always fits DATA_W+GAIN_W bits since damp < 2^GAIN_W;
    // dropping the low bits gives the floor of the scaled value.
    assign w_data_ext = {{GAIN_W{r_rdata[DATA_W-1]}}, r_rdata};
    assign w_gain_ext = {{DATA_W{1'b0}}, w_damp_ch};
    assign w_product  = w_data_ext * w_gain_ext;
    assign {w_result, w_frac_unused} = w_product;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= r_sample;
        else          r_rdata <= r_mem[w_mem_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_fill     <= '0;
            r_ch       <= '0;
            r_sample   <= '0;
            r_delay    <= '0;
            r_damp     <= '0;
            signal_out <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (sample_en && (r_state != S_IDLE)) overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (sample_en) begin
                        r_sample <= signal_in;
                        r_delay  <= delay;
                        r_damp   <= damp;
                    end
                end
                S_WRITE: begin
                    if (r_fill != C_FULL) r_fill <= r_fill + (ADDR_W + 1)'(1);
                    r_ch <= '0;
                end
                S_MAC: begin
                    if (r_ch != C_LAST_CH) r_ch <= r_ch + CH_W'(1);
                end
                S_DONE: begin
                    signal_out <= w_shadow_flat;
                    out_valid  <= 1'b1;
                    r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_shadow
        logic [DATA_W-1:0] r_shadow;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_shadow <= '0;
            end else if ((r_state == S_MAC) && (r_ch == CH_W'(c))) begin
                r_shadow <= w_tap_valid ? w_result : '0;
            end
        end
        assign w_shadow_flat[c*DATA_W +: DATA_W] = r_shadow;
    end

endmodule
`default_nettype wire

// File: doc/delay_line_mc.md
# delay_line_mc

Multi-channel parametrised delay line for the surround pipeline. One mono source sample enters per sample-rate strobe. The block writes it into an internal circular buffer and produces CHANNELS delayed, damped copies, one per output channel. Each channel has its own delay in samples and its own gain. It replaces the fixed single-tap delay path and sits between the 44 kHz sample source and the per-speaker mixers.

## Interface
- DATA_W, 16, signed sample width (two's complement)
- DEPTH, 256, buffer depth in samples; power of 2, ≥ 4; ADDR_W = clog2(DEPTH)
- CHANNELS, 2, number of output taps, ≥ 1
- GAIN_W, 8, unsigned damp width; gain = damp / 2^GAIN_W
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_en  in  1  one-cycle sample-rate strobe
- signal_in  in  DATA_W  source sample, captured with sample_en
- delay  in  CHANNELS*ADDR_W  per-channel delay in samples; channel c at [c*ADDR_W +: ADDR_W]
- damp  in  CHANNELS*GAIN_W  per-channel gain; channel c at [c*GAIN_W +: GAIN_W]
- signal_out  out  CHANNELS*DATA_W  delayed, damped samples; channel c at [c*DATA_W +: DATA_W]
- out_valid  out  1  one-cycle pulse when signal_out updates
- overrun  out  1  sticky; set when a sample_en is dropped

## Operation
- Storage: single-port synchronous-read RAM, DEPTH x DATA_W. It allows one access per cycle and has no reset; contents are undefined after reset.
- Registers: wr_ptr (ADDR_W, wraps modulo DEPTH), fill (0..DEPTH, saturating), ch index, sample/delay/damp snapshot, per-channel shadow results.
- FSM states:
  - IDLE: on sample_en, snapshot signal_in, delay and damp → WRITE.
  - WRITE: mem[wr_ptr] ← sample; fill ← min(fill+1, DEPTH); ch ← 0 → READ.
  - READ: address = (wr_ptr − delay[ch]) mod DEPTH → MAC.
  - MAC: shadow[ch] ← tap ? product : 0. If ch = CHANNELS−1 → DONE, else ch+1 → READ.
  - DONE: signal_out ← all shadows at once; out_valid ← 1; wr_ptr ← wr_ptr+1 → IDLE.
- Tap valid rule: tap is valid iff delay[ch] < fill, with fill taken after the WRITE increment. Unwritten locations never reach the output; invalid taps output 0.
- Delay 0 returns the sample written in the same operation.
- Arithmetic:
  - product = signed(data) × signed({1'b0, damp}), width DATA_W+GAIN_W+1.
  - Result is bits [DATA_W+GAIN_W−1 : GAIN_W]. This is an arithmetic shift right by GAIN_W, rounding toward −∞.
  - No saturation is needed, because damp ≤ 2^GAIN_W − 1 always gives |result| ≤ |data|.
- Overrun: sample_en in any state other than IDLE is ignored, and overrun ← 1. overrun clears only on reset. An in-progress operation is never disturbed by an ignored strobe.
- delay and damp are sampled only in IDLE with sample_en; changes at other times have no effect on the current operation.

## Timing
- Reset (async assert, sync-release-safe): state = IDLE, wr_ptr = 0, fill = 0, ch = 0, signal_out = 0, out_valid = 0, overrun = 0.
- Reset mid-operation aborts immediately: no out_valid pulse and no wr_ptr advance. Buffer history is logically discarded via fill = 0.
- Latency: sample_en high in cycle t → WRITE t+1 → READ/MAC pairs t+2 … t+1+2·CHANNELS → DONE t+2+2·CHANNELS. out_valid is high and signal_out is new in cycle t+3+2·CHANNELS.
- out_valid is exactly one cycle wide; signal_out holds its value between pulses.
- Minimum sample_en spacing is 2·CHANNELS+3 cycles. A strobe in the out_valid cycle is accepted, since the FSM is already in IDLE.
- At 44.1 kHz with a typical 100 MHz clk, CHANNELS up to ~1000 fits within one sample period.

## Test plan
- Reset/idle: hold rst_n=0, then release with no sample_en → signal_out=0, out_valid=0, overrun=0 for 100 cycles.
- Two taps (DEPTH=8, CHANNELS=2, GAIN_W=8): delay={3,0}, damp={128,255}, inputs 100, 200, 300, 400.
  - ch0 outputs 99, 199, 298, 398 (e.g. 100·255>>8 = 99).
  - ch1 outputs 0, 0, 0, 50, since the tap is valid only once fill ≥ 4.
  - out_valid arrives exactly 7 cycles after each sample_en.
- Negative rounding: ch0 delay 0, damp 128; inputs −100 and −101 → −50 and −51.
- Wrap-around (DEPTH=8): write 10 samples valued 1..10, then the 11th with ch0 delay=7 → output (4·255)>>8 = 3. This reads sample 4 at wrapped address 3.
- Overrun: second sample_en 3 cycles after the first → ignored; overrun=1 and stays 1. The first result is unaffected, and only one out_valid pulse occurs.
- Reset mid-operation: assert rst_n during READ → out_valid never pulses and outputs=0. After release, the next sample with delay=1 → output 0, because fill=1.
